// File: rtl/cmsdk_ahb_sram_wbuf.sv
// Zero-wait AHB-Lite SRAM slave; reads return 1 cycle after address phase, writes retire in the data phase
// or via a one-entry buffer when a read address phase takes the SRAM port. Only bad transfers stall (2-cycle ERROR).
module cmsdk_ahb_sram_wbuf #(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWEN,
    output logic          SRAMCS
);

    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

    state_t        state_q, state_d;
    logic          rd_dp_q, wr_dp_q;
    logic [AW-3:0] dp_addr_q;
    logic [3:0]    dp_wen_q;
    logic          buf_valid_q, buf_valid_d;
    logic [AW-3:0] buf_addr_q;
    logic [3:0]    buf_wen_q;
    logic [31:0]   buf_data_q;

    logic          acc, bad, good_racc, good_wacc, buf_ld;
    logic [3:0]    strb;
    logic [31:0]   merged;
    logic          unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    assign acc = HSEL & HREADY & HTRANS[1];
    assign bad = acc & ((HSIZE > 3'd2) ||
                        (HSIZE == 3'd1 && HADDR[0]) ||
                        (HSIZE == 3'd2 && HADDR[1:0] != 2'b00));
    assign good_racc = acc & ~bad & ~HWRITE;
    assign good_wacc = acc & ~bad & HWRITE;
    // A write data phase colliding with a read address phase parks in the buffer.
    assign buf_ld    = wr_dp_q & good_racc;

    always_comb begin
        strb = 4'b1111;
        case (HSIZE[1:0])
            2'd0:    strb = 4'b0001 << HADDR[1:0];
            2'd1:    strb = HADDR[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_dp_q   <= 1'b0;
            wr_dp_q   <= 1'b0;
            dp_addr_q <= '0;
            dp_wen_q  <= 4'b0000;
        end else if (HREADY) begin
            rd_dp_q   <= good_racc;
            wr_dp_q   <= good_wacc;
            dp_addr_q <= HADDR[AW-1:2];
            dp_wen_q  <= strb;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_wen_q   <= 4'b0000;
            buf_data_q  <= 32'h0;
        end else begin
            buf_valid_q <= buf_valid_d;
            if (buf_ld) begin
                buf_addr_q <= dp_addr_q;
                buf_wen_q  <= dp_wen_q;
                buf_data_q <= HWDATA;
            end
        end
    end

    // Read owns the port first, then the live write, then the buffered write.
    always_comb begin
        SRAMCS      = 1'b0;
        SRAMWEN     = 4'b0000;
        SRAMADDR    = '0;
        SRAMWDATA   = 32'h0;
        buf_valid_d = buf_valid_q;
        if (good_racc) begin
            SRAMCS   = 1'b1;
            SRAMADDR = HADDR[AW-1:2];
            if (buf_ld) buf_valid_d = 1'b1;
        end else if (wr_dp_q) begin
            SRAMCS    = 1'b1;
            SRAMADDR  = dp_addr_q;
            SRAMWEN   = dp_wen_q;
            SRAMWDATA = HWDATA;
        end else if (buf_valid_q) begin
            SRAMCS      = 1'b1;
            SRAMADDR    = buf_addr_q;
            SRAMWEN     = buf_wen_q;
            SRAMWDATA   = buf_data_q;
            buf_valid_d = 1'b0;
        end
    end

    always_comb begin
        merged = SRAMRDATA;
        for (int i = 0; i < 4; i++) begin
            if (buf_valid_q && buf_addr_q == dp_addr_q && buf_wen_q[i])
                merged[8*i +: 8] = buf_data_q[8*i +: 8];
        end
        HRDATA = rd_dp_q ? merged : 32'h0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_IDLE: if (bad) state_d = ST_ERR1;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = 1'b1;
                state_d = bad ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmsdk_ahb_sram_wbuf.sv
// Directed bench for cmsdk_ahb_sram_wbuf with a behavioural single-port SRAM.
module tb_cmsdk_ahb_sram_wbuf;
    localparam int AW = 16;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] IDL  = 2'b00;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL, HREADY, HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [AW-1:0] HADDR;
    logic [31:0]   HWDATA, HRDATA, SRAMRDATA, SRAMWDATA;
    logic          HREADYOUT, HRESP, SRAMCS;
    logic [AW-3:0] SRAMADDR;
    logic [3:0]    SRAMWEN;
    logic          hold_lo;

    logic [31:0]   mem [0:(1<<(AW-2))-1];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT & ~hold_lo;

    cmsdk_ahb_sram_wbuf #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAMRDATA(SRAMRDATA), .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
        .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
    );

    always @(posedge HCLK) begin
        if (SRAMCS) begin
            if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
            else begin
                for (int i = 0; i < 4; i++)
                    if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [AW-1:0] ad, input logic [31:0] wd);
        HSEL   = (tr != IDL);
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = ad;
        HWDATA = wd;
    endtask

    task automatic neg;
        @(negedge HCLK);
    endtask

    task automatic nxt;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1<<(AW-2)); i++) mem[i] = 32'h0;
        SRAMRDATA = 32'h0;
        hold_lo   = 1'b0;
        HRESETn   = 1'b0;
        drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);

        // reset values
        neg;
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_sramcs", {31'h0, SRAMCS}, 32'h0);
        chk("rst_sramwen", {28'h0, SRAMWEN}, 32'h0);
        nxt;
        HRESETn = 1'b1;
        nxt;

        // single write then read
        drv(NSEQ, 1'b1, 3'd2, 16'h0010, 32'h0);
        neg; chk("w1_addr_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'hDEADBEEF);
        neg;
        chk("w1_dp_wen", {28'h0, SRAMWEN}, 32'hF);
        chk("w1_dp_addr", {18'h0, SRAMADDR}, 32'h4);
        chk("w1_dp_wdata", SRAMWDATA, 32'hDEADBEEF);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg; chk("w1_idle_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0010, 32'h0);
        neg;
        chk("r1_addr_cs", {31'h0, SRAMCS}, 32'h1);
        chk("r1_addr_wen", {28'h0, SRAMWEN}, 32'h0);
        chk("r1_addr_sa", {18'h0, SRAMADDR}, 32'h4);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg;
        chk("r1_hrdata", HRDATA, 32'hDEADBEEF);
        chk("r1_hreadyout", {31'h0, HREADYOUT}, 32'h1);

        // word write, byte write, read of same word (buffer + merge)
        nxt; drv(NSEQ, 1'b1, 3'd2, 16'h0020, 32'h0);
        nxt; drv(NSEQ, 1'b1, 3'd0, 16'h0021, 32'h11223344);
        neg; chk("m_w1_wen", {28'h0, SRAMWEN}, 32'hF);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0020, 32'h0000AA00);
        neg;
        chk("m_rd_wins_cs", {31'h0, SRAMCS}, 32'h1);
        chk("m_rd_wins_wen", {28'h0, SRAMWEN}, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg;
        chk("m_merge", HRDATA, 32'h1122AA44);
        chk("m_commit_wen", {28'h0, SRAMWEN}, 32'h2);
        chk("m_commit_addr", {18'h0, SRAMADDR}, 32'h8);
        chk("m_commit_wdata", SRAMWDATA & 32'h0000FF00, 32'h0000AA00);
        nxt;
        neg; chk("m_after_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0020, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg; chk("m_reread", HRDATA, 32'h1122AA44);

        // alternating W R W R R
        nxt; drv(NSEQ, 1'b1, 3'd2, 16'h0100, 32'h0);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0010, 32'hA0A0A0A0);
        neg; chk("alt_rdy1", {31'h0, HREADYOUT}, 32'h1);
        nxt; drv(NSEQ, 1'b1, 3'd2, 16'h0104, 32'h0);
        neg;
        chk("alt_rd1", HRDATA, 32'hDEADBEEF);
        chk("alt_commit1_addr", {18'h0, SRAMADDR}, 32'h40);
        chk("alt_commit1_wen", {28'h0, SRAMWEN}, 32'hF);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0100, 32'hB1B1B1B1);
        neg; chk("alt_rdy2", {31'h0, HREADYOUT}, 32'h1);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0104, 32'h0);
        neg; chk("alt_rd2", HRDATA, 32'hA0A0A0A0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg;
        chk("alt_rd3_merge", HRDATA, 32'hB1B1B1B1);
        chk("alt_commit2_addr", {18'h0, SRAMADDR}, 32'h41);
        chk("alt_rdy3", {31'h0, HREADYOUT}, 32'h1);
        nxt;
        neg; chk("alt_idle_cs", {31'h0, SRAMCS}, 32'h0);

        // misaligned word read
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0002, 32'h0);
        neg; chk("err_addr_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg;
        chk("err1_rdy", {31'h0, HREADYOUT}, 32'h0);
        chk("err1_resp", {31'h0, HRESP}, 32'h1);
        chk("err1_cs", {31'h0, SRAMCS}, 32'h0);
        chk("err1_hrdata", HRDATA, 32'h0);
        nxt;
        neg;
        chk("err2_rdy", {31'h0, HREADYOUT}, 32'h1);
        chk("err2_resp", {31'h0, HRESP}, 32'h1);
        chk("err2_cs", {31'h0, SRAMCS}, 32'h0);
        nxt;
        neg;
        chk("err_done_resp", {31'h0, HRESP}, 32'h0);

        // misaligned halfword write and oversize transfer are also errors
        nxt; drv(NSEQ, 1'b1, 3'd1, 16'h0005, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h12345678);
        neg;
        chk("errh_resp", {31'h0, HRESP}, 32'h1);
        chk("errh_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; nxt; drv(NSEQ, 1'b0, 3'd3, 16'h0000, 32'h0);
        neg; chk("errsz_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg; chk("errsz_rdy", {31'h0, HREADYOUT}, 32'h0);
        nxt; nxt;

        // halfword write upper lanes
        drv(NSEQ, 1'b1, 3'd1, 16'h0006, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'hBEEF0000);
        neg;
        chk("hw_wen", {28'h0, SRAMWEN}, 32'hC);
        chk("hw_wdata_hi", {16'h0, SRAMWDATA[31:16]}, 32'hBEEF);
        chk("hw_addr", {18'h0, SRAMADDR}, 32'h1);

        // HREADY low with HSEL high is not an accept
        nxt; hold_lo = 1'b1; drv(NSEQ, 1'b0, 3'd2, 16'h0010, 32'h0);
        neg; chk("nordy_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; hold_lo = 1'b0; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg; chk("nordy_hrdata", HRDATA, 32'h0);

        // reset while the buffer holds a write
        nxt; drv(NSEQ, 1'b1, 3'd2, 16'h0200, 32'h0);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0010, 32'h55667788);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        HRESETn = 1'b0;
        neg;
        chk("arst_cs", {31'h0, SRAMCS}, 32'h0);
        chk("arst_hrdata", HRDATA, 32'h0);
        chk("arst_rdy", {31'h0, HREADYOUT}, 32'h1);
        nxt; HRESETn = 1'b1;
        neg; chk("arst_post_cs", {31'h0, SRAMCS}, 32'h0);
        nxt; drv(NSEQ, 1'b0, 3'd2, 16'h0200, 32'h0);
        nxt; drv(IDL, 1'b0, 3'd2, 16'h0, 32'h0);
        neg; chk("arst_no_write", HRDATA, 32'h0);
        nxt;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cmsdk_ahb_sram_wbuf.md
# cmsdk_ahb_sram_wbuf

Zero-wait-state AHB-Lite slave that connects one synchronous single-port 32-bit SRAM to the bus. It drives one HREADYOUTn/HRESPn/HRDATAn port of the AHB slave multiplexer. Read and write traffic share the single SRAM port. A one-entry write buffer absorbs collisions between a write data phase and a read address phase, and buffered bytes are merged into read data. Misaligned or unsupported transfers get a two-cycle ERROR response and do not touch the SRAM.

## Interface
Parameters:
- AW, 16: byte address width. The SRAM holds 2^(AW-2) words.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select from the address decoder
- HREADY  in  1  bus ready; the transfer-accept qualifier
- HTRANS  in  2  transfer type; bit 1 set means a valid transfer
- HSIZE  in  3  transfer size: 0 byte, 1 halfword, 2 word
- HWRITE  in  1  write when 1
- HADDR  in  AW  byte address
- HWDATA  in  32  write data, valid in the write data phase
- HREADYOUT  out  1  ready to the slave multiplexer
- HRESP  out  1  response: 1 is ERROR
- HRDATA  out  32  read data
- SRAMRDATA  in  32  SRAM read data, valid the cycle after SRAMCS with SRAMWEN=0
- SRAMADDR  out  AW-2  SRAM word address
- SRAMWDATA  out  32  SRAM write data
- SRAMWEN  out  4  per-byte write enables
- SRAMCS  out  1  SRAM chip select

## Operation
- Accept condition: acc = HSEL & HREADY & HTRANS[1]. An accepted transfer is either a read (racc) or a write (wacc).
- Error check: the accepted transfer is bad when any of these holds:
  - HSIZE > 2
  - HSIZE = 1 and HADDR[0] = 1
  - HSIZE = 2 and HADDR[1:0] != 0
- Byte strobes:
  - byte: one-hot on HADDR[1:0]
  - halfword: 4'b1100 if HADDR[1] = 1, else 4'b0011
  - word: 4'b1111
- Data-phase registers, loaded on every HREADY=1 edge: rd_dp, wr_dp, dp_addr[AW-3:0], dp_wen[3:0]. All clear on reset. Bad transfers load rd_dp = wr_dp = 0.
- Error FSM states: IDLE, ERR1, ERR2.
  - A bad acc moves IDLE to ERR1.
  - ERR1 always moves to ERR2.
  - ERR2 moves to ERR1 on another bad acc, otherwise to IDLE.
- Response outputs per state:
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1.
  - IDLE: HREADYOUT = 1, HRESP = 0.
- Read path: a good racc drives SRAMCS = 1, SRAMWEN = 0 and SRAMADDR = HADDR[AW-1:2] combinationally in the address phase.
- HRDATA:
  - In a read data phase, HRDATA is the merged data (below).
  - Outside a read data phase, HRDATA is 0.
- Write path, in a cycle with wr_dp = 1:
  - If no good racc is present, write SRAM directly: SRAMCS = 1, SRAMADDR = dp_addr, SRAMWEN = dp_wen, SRAMWDATA = HWDATA.
  - If a good racc is present, the read owns the port. At the edge, load buf_addr, buf_wen and buf_data (from HWDATA), and set buf_valid.
- Buffer commit: a cycle with buf_valid = 1, no good racc and wr_dp = 0 drives SRAM from the buffer and clears buf_valid at the edge.
- Buffer capacity: every write address-phase cycle has a free port, so the buffer is always empty before a new write can need it. The buffer never holds more than one entry.
- Read merge: in a read data phase with buf_valid = 1 and buf_addr = dp_addr, each byte lane with buf_wen set returns buf_data. Other lanes return SRAMRDATA.
- Outputs when no SRAM access is needed: SRAMCS = 0, SRAMWEN = 0, SRAMADDR = 0, SRAMWDATA = 0.

## Timing
- Reset values:
  - Bus outputs: HREADYOUT = 1, HRESP = 0, HRDATA = 0.
  - SRAM outputs: SRAMCS = 0, SRAMWEN = 0.
  - State: buf_valid = 0, FSM = IDLE.
  - Reset mid-transfer discards the buffer contents.
- Good reads: data appears 1 cycle after the address phase, with zero wait states.
- Good writes: complete at the end of the data phase, with zero wait states. The SRAM update happens in the data phase, or is deferred until the next free cycle.
- Bad transfers: take exactly 2 data-phase cycles (ERR1, then ERR2), with no SRAM activity.
- HREADY = 0 with HSEL = 1 is not an accept. No data-phase registers change.
- Long read bursts leave the buffer pending indefinitely. Reads to the buffered word stay coherent through the merge.

## Test plan
- Single write then read: write 0xDEADBEEF to 0x0010, then idle, then read 0x0010.
  - Write data phase: SRAMWEN = 4'hF.
  - Read data phase: HRDATA = 0xDEADBEEF.
- Write immediately followed by a read of the same word: word write 0x11223344 to 0x20, then byte write 0xAA to 0x21, then read 0x20.
  - The byte write is buffered.
  - The read data phase returns 0x1122AA44 via the merge.
  - The SRAM commit with SRAMWEN = 4'b0010 occurs on the next free cycle.
- Alternating stream W, R, W, R to distinct addresses.
  - Every HREADYOUT stays 1.
  - buf_valid never exceeds one entry.
  - All read data is correct.
- Misaligned word read at 0x0002:
  - HREADYOUT = 0, HRESP = 1, then HREADYOUT = 1, HRESP = 1.
  - SRAMCS = 0 throughout.
- Halfword write 0xBEEF to 0x0006.
  - SRAMWEN = 4'b1100.
  - SRAMWDATA lanes [31:16] = 0xBEEF.
- Assert HRESETn low while buf_valid = 1:
  - Outputs return to reset values immediately.
  - No SRAM write follows.
